// File: rtl/icache_pkg.sv
// Shared instruction-cache geometry and refill sequencer state encoding.
package icache_pkg;

   localparam int unsigned ICACHE_BLOCK_WIDTH = 512;
   localparam int unsigned ICACHE_WORD_SIZE   = 32;
   localparam int unsigned ICACHE_ADDR_WIDTH  = 32;
   localparam int unsigned BEAT_COUNT         = ICACHE_BLOCK_WIDTH / ICACHE_WORD_SIZE;
   localparam int unsigned BEAT_W             = $clog2(BEAT_COUNT);
   localparam int unsigned OFFSET_W           = $clog2(ICACHE_BLOCK_WIDTH / 8);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      WRITE
   } t_refill_state;

endpackage

// File: rtl/refill_line_buffer.sv
// Beat counter plus indexed assembly register for one cache line refill.
module refill_line_buffer #(
   parameter int unsigned BLOCK_WIDTH = 512,
   parameter int unsigned WORD_SIZE   = 32
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   clear_i,
   input  logic                   load_i,
   input  logic [WORD_SIZE-1:0]   data_i,
   output logic [BLOCK_WIDTH-1:0] line_o,
   output logic                   last_o
);

   localparam int unsigned NumBeats = BLOCK_WIDTH / WORD_SIZE;
   localparam int unsigned CntW     = $clog2(NumBeats);

   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [BLOCK_WIDTH-1:0] line_q, line_d;

   assign last_o = (cnt_q == CntW'(NumBeats - 1));
   assign line_o = line_q;

   always_comb begin
      cnt_d  = cnt_q;
      line_d = line_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         for (int unsigned i = 0; i < NumBeats; i++) begin
            if (cnt_q == CntW'(i)) begin
               line_d[i*WORD_SIZE +: WORD_SIZE] = data_i;
            end
         end
         // Counter parks on the last beat; the FSM leaves FILL on that beat.
         if (!last_o) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         cnt_q  <= '0;
         line_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache miss sequencer: one block read per miss, line write-back,
// and fence.i invalidation that never interleaves with a refill.
module icache_refill_ctrl
   import icache_pkg::*;
#(
   parameter int unsigned BLOCK_WIDTH = ICACHE_BLOCK_WIDTH,
   parameter int unsigned WORD_SIZE   = ICACHE_WORD_SIZE,
   parameter int unsigned ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   i_fetch_req,
   input  logic [ADDR_WIDTH-1:0]  i_instr_addr,
   input  logic                   i_hit,
   input  logic                   i_instr_addr_ma,
   input  logic                   i_fence_i,
   output logic [ADDR_WIDTH-1:0]  o_cache_addr,
   output logic                   o_cache_we,
   output logic [BLOCK_WIDTH-1:0] o_cache_line,
   output logic                   o_invalidate,
   output logic                   o_stall,
   output logic                   o_mem_arvalid,
   output logic [ADDR_WIDTH-1:0]  o_mem_araddr,
   input  logic                   i_mem_arready,
   input  logic                   i_mem_rvalid,
   input  logic [WORD_SIZE-1:0]   i_mem_rdata,
   output logic [31:0]            o_miss_count
);

   localparam int unsigned OffW = $clog2(BLOCK_WIDTH / 8);

   t_refill_state         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           miss_cnt_q, miss_cnt_d;
   logic                  fence_pend_q, fence_pend_d;
   logic                  inval_q, inval_d;
   logic                  miss, buf_clear, buf_load, buf_last;

   assign miss = i_fetch_req & ~i_hit & ~i_instr_addr_ma;

   refill_line_buffer #(
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .WORD_SIZE   (WORD_SIZE)
   ) u_line_buffer (
      .clk     (clk),
      .arst    (arst),
      .clear_i (buf_clear),
      .load_i  (buf_load),
      .data_i  (i_mem_rdata),
      .line_o  (o_cache_line),
      .last_o  (buf_last)
   );

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      miss_cnt_d    = miss_cnt_q;
      fence_pend_d  = fence_pend_q;
      inval_d       = 1'b0;
      o_stall       = 1'b0;
      o_mem_arvalid = 1'b0;
      o_cache_we    = 1'b0;
      buf_clear     = 1'b0;
      buf_load      = 1'b0;
      unique case (state_q)
         IDLE: begin
            o_stall = miss;
            // A fence or a pending invalidate holds off the miss for re-evaluation.
            if (i_fence_i) begin
               inval_d = 1'b1;
            end else if (miss && !inval_q) begin
               state_d = REQ;
               addr_d  = {i_instr_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
               if (miss_cnt_q != '1) begin
                  miss_cnt_d = miss_cnt_q + 32'd1;
               end
            end
         end
         REQ: begin
            o_stall       = 1'b1;
            o_mem_arvalid = 1'b1;
            if (i_fence_i) fence_pend_d = 1'b1;
            if (i_mem_arready) begin
               state_d   = FILL;
               buf_clear = 1'b1;
            end
         end
         FILL: begin
            o_stall  = 1'b1;
            buf_load = i_mem_rvalid;
            if (i_fence_i) fence_pend_d = 1'b1;
            if (i_mem_rvalid && buf_last) state_d = WRITE;
         end
         WRITE: begin
            o_stall      = 1'b1;
            o_cache_we   = 1'b1;
            inval_d      = fence_pend_q | i_fence_i;
            fence_pend_d = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_cache_addr = (state_q != IDLE)
                       ? (addr_q | {{(ADDR_WIDTH-OffW){1'b0}}, i_instr_addr[OffW-1:0]})
                       : i_instr_addr;
   assign o_mem_araddr = addr_q;
   assign o_invalidate = inval_q;
   assign o_miss_count = miss_cnt_q;

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         miss_cnt_q   <= '0;
         fence_pend_q <= 1'b0;
         inval_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         miss_cnt_q   <= miss_cnt_d;
         fence_pend_q <= fence_pend_d;
         inval_q      <= inval_d;
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus queues expected reads and
// line writes, a negedge monitor pops and compares them.
module tb_icache_refill_ctrl;

   localparam int unsigned BW = 512;
   localparam int unsigned WS = 32;
   localparam int unsigned AW = 32;

   logic          clk;
   logic          arst;
   logic          i_fetch_req;
   logic [AW-1:0] i_instr_addr;
   logic          i_hit;
   logic          i_instr_addr_ma;
   logic          i_fence_i;
   logic [AW-1:0] o_cache_addr;
   logic          o_cache_we;
   logic [BW-1:0] o_cache_line;
   logic          o_invalidate;
   logic          o_stall;
   logic          o_mem_arvalid;
   logic [AW-1:0] o_mem_araddr;
   logic          i_mem_arready;
   logic          i_mem_rvalid;
   logic [WS-1:0] i_mem_rdata;
   logic [31:0]   o_miss_count;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [BW-1:0] exp_line_q[$];
   logic [AW-1:0] exp_waddr_q[$];
   logic [AW-1:0] exp_ar_q[$];

   icache_refill_ctrl dut (
      .clk             (clk),
      .arst            (arst),
      .i_fetch_req     (i_fetch_req),
      .i_instr_addr    (i_instr_addr),
      .i_hit           (i_hit),
      .i_instr_addr_ma (i_instr_addr_ma),
      .i_fence_i       (i_fence_i),
      .o_cache_addr    (o_cache_addr),
      .o_cache_we      (o_cache_we),
      .o_cache_line    (o_cache_line),
      .o_invalidate    (o_invalidate),
      .o_stall         (o_stall),
      .o_mem_arvalid   (o_mem_arvalid),
      .o_mem_araddr    (o_mem_araddr),
      .i_mem_arready   (i_mem_arready),
      .i_mem_rvalid    (i_mem_rvalid),
      .i_mem_rdata     (i_mem_rdata),
      .o_miss_count    (o_miss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [BW-1:0] got,
                               input logic [BW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   // Monitor: pops expected line writes and read addresses as the DUT presents them.
   always @(negedge clk) begin
      if (!arst) begin
         if (o_cache_we) begin
            if (exp_line_q.size() == 0) begin
               chk("unexpected_cache_we", 1'b1, 1'b0);
            end else begin
               chk("cache_line", o_cache_line, exp_line_q.pop_front());
               chk("cache_addr", o_cache_addr, exp_waddr_q.pop_front());
            end
         end
         if (o_mem_arvalid) begin
            if (exp_ar_q.size() == 0) begin
               chk("unexpected_arvalid", 1'b1, 1'b0);
            end else begin
               chk("mem_araddr", o_mem_araddr, exp_ar_q[0]);
               if (i_mem_arready) void'(exp_ar_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full refill: one miss, ar_delay cycles of arready low, a one-cycle rvalid gap
   // after each beat flagged in gap_after, optional fence pulse with beat fence_beat.
   task automatic refill(input logic [AW-1:0] addr, input logic [WS-1:0] base,
                         input int ar_delay, input logic [15:0] gap_after,
                         input int fence_beat, output int stalls);
      logic [BW-1:0] line;
      int            beat, ar_wait;
      bit            in_fill, gap_now, done, av;
      for (int i = 0; i < 16; i++) line[i*WS +: WS] = base + WS'(i);
      exp_line_q.push_back(line);
      exp_waddr_q.push_back(addr);
      exp_ar_q.push_back({addr[AW-1:6], 6'b0});
      i_fetch_req     = 1'b1;
      i_hit           = 1'b0;
      i_instr_addr_ma = 1'b0;
      i_instr_addr    = addr;
      beat = 0; ar_wait = 0; in_fill = 0; gap_now = 0; done = 0; stalls = 0;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         i_mem_arready = (ar_wait >= ar_delay);
         i_mem_rvalid  = in_fill && !gap_now && beat < 16;
         i_mem_rdata   = base + WS'(beat);
         i_fence_i     = i_mem_rvalid && beat == fence_beat;
         @(negedge clk);
         av = o_mem_arvalid;
         if (o_stall) stalls++;
         if (o_cache_we) done = 1;
         step();
         if (av) begin
            if (i_mem_arready) in_fill = 1;
            else ar_wait++;
         end
         if (i_mem_rvalid) begin
            gap_now = gap_after[beat];
            beat++;
         end else begin
            gap_now = 0;
         end
      end
      if (!done) chk("cache_we_timeout", 1'b0, 1'b1);
      i_hit         = 1'b1;
      i_mem_rvalid  = 1'b0;
      i_mem_arready = 1'b0;
      i_fence_i     = 1'b0;
      @(negedge clk);
      chk("stall_after_write", o_stall, 1'b0);
   endtask

   int stalls;

   initial begin
      arst = 1'b1; i_fetch_req = 1'b0; i_instr_addr = 32'h0000_1234; i_hit = 1'b0;
      i_instr_addr_ma = 1'b0; i_fence_i = 1'b0; i_mem_arready = 1'b0;
      i_mem_rvalid = 1'b0; i_mem_rdata = '0;
      step(); step();
      @(negedge clk);
      chk("rst_stall", o_stall, 1'b0);
      chk("rst_arvalid", o_mem_arvalid, 1'b0);
      chk("rst_cache_we", o_cache_we, 1'b0);
      chk("rst_invalidate", o_invalidate, 1'b0);
      chk("rst_miss_count", o_miss_count, 32'd0);
      chk("rst_cache_line", o_cache_line, '0);
      chk("rst_cache_addr", o_cache_addr, 32'h0000_1234);
      step();
      arst = 1'b0;

      // 1: basic refill, 19 stall cycles with we in the last
      refill(32'h0000_0104, 32'hA0, 0, 16'h0000, -1, stalls);
      chk("t1_stalls", stalls, 19);
      chk("t1_miss_count", o_miss_count, 32'd1);
      step();
      i_fetch_req = 1'b0;

      // 2: arready held low 5 cycles, gaps after beats 3 and 9
      refill(32'h0000_0104, 32'hA0, 5, 16'h0208, -1, stalls);
      chk("t2_stalls", stalls, 26);
      chk("t2_miss_count", o_miss_count, 32'd2);
      step();
      i_fetch_req = 1'b0;

      // 3a: fence coinciding with a miss in IDLE wins, miss waits
      i_fetch_req = 1'b1; i_hit = 1'b0; i_instr_addr = 32'h0000_0300; i_fence_i = 1'b1;
      @(negedge clk);
      chk("t3_fence_miss_stall", o_stall, 1'b1);
      chk("t3_fence_miss_arvalid", o_mem_arvalid, 1'b0);
      step();
      i_fence_i = 1'b0;
      @(negedge clk);
      chk("t3_idle_invalidate", o_invalidate, 1'b1);
      chk("t3_inval_stall", o_stall, 1'b1);
      chk("t3_inval_arvalid", o_mem_arvalid, 1'b0);
      step();
      // 3b: fence during FILL beat 7 deferred until after WRITE
      refill(32'h0000_0300, 32'hB0, 0, 16'h0000, 7, stalls);
      chk("t3_stalls", stalls, 19);
      chk("t3_post_invalidate", o_invalidate, 1'b1);
      chk("t3_post_arvalid", o_mem_arvalid, 1'b0);
      step();
      @(negedge clk);
      chk("t3_invalidate_single", o_invalidate, 1'b0);
      chk("t3_miss_count", o_miss_count, 32'd3);
      step();
      i_fetch_req = 1'b0;

      // 4: misaligned fetch never stalls nor requests
      i_fetch_req = 1'b1; i_hit = 1'b0; i_instr_addr_ma = 1'b1; i_instr_addr = 32'h0000_0102;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_stall", o_stall, 1'b0);
         chk("t4_arvalid", o_mem_arvalid, 1'b0);
         step();
      end
      chk("t4_miss_count", o_miss_count, 32'd3);
      i_fetch_req = 1'b0; i_instr_addr_ma = 1'b0;

      // 5: reset at FILL beat 5, trailing beats must be ignored
      exp_ar_q.push_back(32'h0000_0200);
      i_fetch_req = 1'b1; i_hit = 1'b0; i_instr_addr = 32'h0000_0208; i_mem_arready = 1'b1;
      step();
      step();
      i_mem_arready = 1'b0;
      for (int b = 0; b < 16; b++) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = 32'hE0 + WS'(b);
         arst         = (b == 5);
         if (b > 5) begin
            i_fetch_req = 1'b0;
            @(negedge clk);
            chk("t5_idle_stall", o_stall, 1'b0);
            chk("t5_idle_arvalid", o_mem_arvalid, 1'b0);
         end
         step();
      end
      i_mem_rvalid = 1'b0;
      @(negedge clk);
      chk("t5_miss_count", o_miss_count, 32'd0);
      step();
      refill(32'h0000_0240, 32'hC0, 0, 16'h0000, -1, stalls);
      chk("t5_restart_stalls", stalls, 19);
      chk("t5_restart_miss_count", o_miss_count, 32'd1);
      step();
      i_fetch_req = 1'b0;

      // 6: miss counter saturates
      force dut.miss_cnt_q = 32'hFFFF_FFFE;
      step();
      release dut.miss_cnt_q;
      step();
      @(negedge clk);
      chk("t6_preload", o_miss_count, 32'hFFFF_FFFE);
      step();
      refill(32'h0000_0400, 32'hD0, 0, 16'h0000, -1, stalls);
      chk("t6_count_first", o_miss_count, 32'hFFFF_FFFF);
      step();
      i_fetch_req = 1'b0;
      refill(32'h0000_0440, 32'hD0, 1, 16'h0000, -1, stalls);
      chk("t6_count_saturated", o_miss_count, 32'hFFFF_FFFF);
      step();
      i_fetch_req = 1'b0;
      step();

      chk("pending_lines", exp_line_q.size(), 0);
      chk("pending_reads", exp_ar_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-handling sequencer for the direct-mapped instruction cache.
- On a fetch miss it stalls the front end and issues one block-aligned read on the 32-bit memory read bus.
- It assembles the returned beats into a BLOCK_WIDTH line, then pulses the cache write enable for one cycle.
- It also sequences fence.i invalidation so a flush never interleaves with a refill.
- Sits between the fetch stage, instr_cache and the memory/bus interface.

Parameters:
BLOCK_WIDTH, 512, cache line width in bits
WORD_SIZE, 32, memory beat width in bits
ADDR_WIDTH, 32, byte address width
(derived: BEAT_COUNT = BLOCK_WIDTH/WORD_SIZE = 16; BEAT_W = clog2(BEAT_COUNT) = 4; OFFSET_W = clog2(BLOCK_WIDTH/8) = 6)

Ports:
clk  in  1  clock
arst  in  1  reset, synchronous, active-high
i_fetch_req  in  1  fetch stage presents a valid address this cycle
i_instr_addr  in  ADDR_WIDTH  fetch byte address
i_hit  in  1  cache hit for the current cache address
i_instr_addr_ma  in  1  misaligned fetch address from cache
i_fence_i  in  1  invalidate request (single-cycle pulse)
o_cache_addr  out  ADDR_WIDTH  address driven to the cache
o_cache_we  out  1  cache line write enable
o_cache_line  out  BLOCK_WIDTH  assembled line to the cache
o_invalidate  out  1  cache invalidate pulse
o_stall  out  1  fetch stall
o_mem_arvalid  out  1  read address valid
o_mem_araddr  out  ADDR_WIDTH  block-aligned read address
i_mem_arready  in  1  read address accepted
i_mem_rvalid  in  1  read data beat valid
i_mem_rdata  in  WORD_SIZE  read data beat
o_miss_count  out  32  saturating refill counter

Behaviour:
- Reset values: state IDLE; all outputs 0 except o_cache_addr, which follows i_instr_addr. Line buffer, beat counter, fence-pending flag and miss counter are all cleared.
- Reset mid-refill: abandon the refill, write nothing to the cache, and ignore any later rvalid beats while in IDLE.
- States: IDLE, REQ, FILL, WRITE.
- IDLE:
  - A miss is defined as i_fetch_req & ~i_hit & ~i_instr_addr_ma.
  - On a miss: latch addr_q = i_instr_addr with the low OFFSET_W bits zeroed, go to REQ, increment o_miss_count (saturates at 0xFFFFFFFF).
  - o_stall = miss, combinationally in the same cycle.
  - A misaligned fetch never starts a refill and never stalls.
- REQ:
  - o_mem_arvalid=1 and o_mem_araddr=addr_q, both held stable until i_mem_arready.
  - On arready: go to FILL with beat counter 0.
  - rvalid seen in REQ is ignored.
- FILL:
  - Each cycle with i_mem_rvalid=1, write i_mem_rdata into line bits [cnt*WORD_SIZE +: WORD_SIZE], then cnt++.
  - Beat 0 lands in the lowest word.
  - The beat with cnt==BEAT_COUNT-1 moves the FSM to WRITE. The counter does not wrap past 15.
  - Gaps (rvalid=0) are allowed and hold state.
- WRITE:
  - o_cache_we=1 for exactly one cycle, with o_cache_line = the assembled buffer; then go to IDLE.
  - The cache sees a hit on the following cycle.
- Stall and address outputs:
  - o_stall=1 in REQ, FILL and WRITE.
  - o_cache_addr = addr_q | (i_instr_addr low OFFSET_W bits) whenever state != IDLE; otherwise i_instr_addr.
- Fence handling:
  - i_fence_i in IDLE: o_invalidate=1 on the next cycle.
  - If i_fence_i coincides with a miss in IDLE, the invalidate takes priority: no refill starts that cycle, o_stall stays 1, and the miss is re-evaluated after the invalidate.
  - i_fence_i in REQ, FILL or WRITE sets fence_pending. The refill completes normally; o_invalidate pulses on the first IDLE cycle after WRITE, and no new refill starts in that cycle.
- Miss-to-hit latency, with arready in REQ and 16 back-to-back beats: 1 (IDLE->REQ) + 1 (REQ) + 16 (FILL) + 1 (WRITE) = 19 cycles of stall.

Decomposition:
- Shared package icache_pkg: state enum t_refill_state {IDLE, REQ, FILL, WRITE}, plus constants for BEAT_COUNT and OFFSET_W derived from the cache geometry (used by instr_cache too).
- One natural sub-module: refill_line_buffer. Holds the beat counter and the indexed 512-bit assembly register, with load/clear/full signals.

Test Plan:
1. Reset, then miss at 0x0000_0104; arready=1 at once, 16 consecutive beats 0xA0..0xAF -> o_mem_araddr=0x0000_0100; o_cache_we pulses in cycle 19; o_cache_line[31:0]=0xA0 and [511:480]=0xAF; o_miss_count=1.
2. Hold arready low 5 cycles, insert rvalid gaps after beats 3 and 9 -> araddr/arvalid stable throughout, stall extends exactly by the gap count, line contents unchanged versus test 1.
3. i_fence_i during FILL beat 7 -> refill completes, o_cache_we pulses, o_invalidate pulses on the next cycle, no o_mem_arvalid in that cycle.
4. Misaligned fetch 0x0000_0102 with i_hit=0 -> o_stall=0, o_mem_arvalid never asserted, miss count unchanged.
5. arst asserted at FILL beat 5, then beats 6..15 still arrive -> no o_cache_we; state IDLE; o_miss_count=0; a subsequent miss restarts with beat index 0.
6. Preload o_miss_count near saturation (force), then trigger 2 misses -> counter holds 0xFFFFFFFF.
